// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit with HI/LO registers and fixed-latency mult/div.
// Results are computed at issue and committed to HI/LO when the busy countdown expires.
module mult_div_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Start,
  input  logic [3:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Req,
  output logic             Busy,
  output logic             BusyOrStart,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] MDOut
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  hi_tmp, lo_tmp;
  logic              wr_pend;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, uq, ur, q_s, r_s;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic [CW-1:0]      res_cycles;
  logic               res_write, is_md, issue;

  assign prod_s = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
  assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  // Signed divide via magnitudes: sidesteps the MIN/-1 overflow and gives
  // truncation toward zero with the remainder taking the dividend's sign.
  assign a_neg = A[WIDTH-1];
  assign b_neg = B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;
  assign uq    = a_mag / b_mag;
  assign ur    = a_mag % b_mag;
  assign q_s   = (a_neg ^ b_neg) ? -uq : uq;
  assign r_s   = a_neg ? -ur : ur;

  always_comb begin
    res_hi     = '0;
    res_lo     = '0;
    res_cycles = MULT_N;
    res_write  = 1'b1;
    is_md      = 1'b1;
    case (MDOp)
      OP_MULT:  begin res_hi = prod_s[2*WIDTH-1:WIDTH]; res_lo = prod_s[WIDTH-1:0]; end
      OP_MULTU: begin res_hi = prod_u[2*WIDTH-1:WIDTH]; res_lo = prod_u[WIDTH-1:0]; end
      OP_DIV:   begin res_hi = r_s; res_lo = q_s; res_cycles = DIV_N; res_write = (B != '0); end
      OP_DIVU:  begin res_hi = A % B; res_lo = A / B; res_cycles = DIV_N; res_write = (B != '0); end
      default:  is_md = 1'b0;
    endcase
  end

  assign issue       = Start & ~Req & (state == IDLE);
  assign Busy        = (state == RUN);
  assign BusyOrStart = Busy | (Start & is_md & ~Req);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      HI      <= '0;
      LO      <= '0;
      hi_tmp  <= '0;
      lo_tmp  <= '0;
      wr_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            if (is_md) begin
              hi_tmp  <= res_hi;
              lo_tmp  <= res_lo;
              wr_pend <= res_write;
              cnt     <= res_cycles;
              state   <= RUN;
            end else if (MDOp == OP_MTHI) begin
              HI <= A;
            end else if (MDOp == OP_MTLO) begin
              LO <= A;
            end
          end
        end
        RUN: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state   <= IDLE;
            wr_pend <= 1'b0;
            if (wr_pend) begin
              HI <= hi_tmp;
              LO <= lo_tmp;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    MDOut = '0;
    case (MDOp)
      OP_MFHI: MDOut = HI;
      OP_MFLO: MDOut = LO;
      default: MDOut = '0;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases plus randomized ops against an
// arithmetic reference model that tracks HI/LO and the remaining busy time.
module tb_mult_div_unit;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        Start;
  logic [3:0]  MDOp;
  logic [31:0] A, B;
  logic        Req;
  logic        Busy, BusyOrStart;
  logic [31:0] HI, LO, MDOut;

  mult_div_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .Req(Req), .Busy(Busy), .BusyOrStart(BusyOrStart), .HI(HI), .LO(LO), .MDOut(MDOut)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int busy_seen = 0;

  // Reference model state
  logic [31:0] m_hi, m_lo, m_rhi, m_rlo;
  int          m_left;
  bit          m_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_rhi = '0; m_rlo = '0; m_left = 0; m_wr = 0;
  endtask

  task automatic compare();
    logic [31:0] exp_md;
    bit md_op;
    md_op  = Start && (MDOp >= 4'd1) && (MDOp <= 4'd4) && !Req;
    exp_md = (MDOp == 4'd7) ? m_hi : (MDOp == 4'd8) ? m_lo : 32'h0;
    chk("busy", {31'b0, Busy}, {31'b0, m_left > 0});
    chk("busy_or_start", {31'b0, BusyOrStart}, {31'b0, (m_left > 0) || md_op});
    chk("hi", HI, m_hi);
    chk("lo", LO, m_lo);
    chk("mdout", MDOut, exp_md);
    if (Busy) busy_seen++;
  endtask

  task automatic model_step(input bit st, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input bit rq);
    int sa, sb, q, r;
    longint p;
    logic [63:0] pu;
    if (!reset_n) begin
      model_reset();
    end else if (m_left > 0) begin
      if (m_left == 1 && m_wr) begin m_hi = m_rhi; m_lo = m_rlo; end
      m_left--;
    end else if (st && !rq) begin
      sa = a; sb = b;
      case (op)
        4'd1: begin p = longint'(sa) * longint'(sb); m_rhi = p[63:32]; m_rlo = p[31:0];
                    m_wr = 1; m_left = MC; end
        4'd2: begin pu = 64'(a) * 64'(b); m_rhi = pu[63:32]; m_rlo = pu[31:0];
                    m_wr = 1; m_left = MC; end
        4'd3: begin
          m_left = DC; m_wr = (b != 0);
          if (b != 0) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin q = sa; r = 0; end
            else begin q = sa / sb; r = sa % sb; end
            m_rlo = q; m_rhi = r;
          end
        end
        4'd4: begin
          m_left = DC; m_wr = (b != 0);
          if (b != 0) begin m_rlo = a / b; m_rhi = a % b; end
        end
        4'd5: m_hi = a;
        4'd6: m_lo = a;
        default: ;
      endcase
    end
  endtask

  task automatic cycle(input bit st, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit rq);
    Start = st; MDOp = op; A = a; B = b; Req = rq;
    #1 compare();
    @(posedge clk);
    model_step(st, op, a, b, rq);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 4'd0, 32'h0, 32'h0, 0);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    Start = 0; MDOp = 0; A = 0; B = 0; Req = 0;
    reset_n = 0;
    model_reset();
    @(negedge clk);
    #1 compare();
    @(negedge clk);
    reset_n = 1;
    idle(2);

    // mult -3 * 5
    busy_seen = 0;
    cycle(1, 4'd1, 32'hFFFFFFFD, 32'd5, 0);
    idle(6);
    chk("mult_busy_cycles", busy_seen, 32'd5);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFF1);

    // multu 0xFFFFFFFF * 2
    cycle(1, 4'd2, 32'hFFFFFFFF, 32'd2, 0);
    idle(6);
    chk("multu_hi", HI, 32'h00000001);
    chk("multu_lo", LO, 32'hFFFFFFFE);

    // div -7 / 2
    busy_seen = 0;
    cycle(1, 4'd3, 32'hFFFFFFF9, 32'd2, 0);
    idle(11);
    chk("div_busy_cycles", busy_seen, 32'd10);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);

    // div MIN / -1
    cycle(1, 4'd3, 32'h80000000, 32'hFFFFFFFF, 0);
    idle(11);
    chk("div_ovf_lo", LO, 32'h80000000);
    chk("div_ovf_hi", HI, 32'h0);

    // divu 7 / 2
    cycle(1, 4'd4, 32'd7, 32'd2, 0);
    idle(11);
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);

    // flushed mult, then divide by zero
    cycle(1, 4'd1, 32'h1234, 32'h5678, 1);
    chk("req_busy", {31'b0, Busy}, 32'h0);
    idle(6);
    chk("req_hi", HI, 32'd1);
    chk("req_lo", LO, 32'd3);
    busy_seen = 0;
    cycle(1, 4'd3, 32'd99, 32'd0, 0);
    idle(11);
    chk("div0_busy_cycles", busy_seen, 32'd10);
    chk("div0_hi", HI, 32'd1);
    chk("div0_lo", LO, 32'd3);

    // mthi then reads
    busy_seen = 0;
    cycle(1, 4'd5, 32'h12345678, 32'h0, 0);
    cycle(1, 4'd8, 32'h0, 32'h0, 0);
    chk("mflo_lit", MDOut, 32'd3);
    cycle(1, 4'd7, 32'h0, 32'h0, 0);
    chk("mfhi_lit", MDOut, 32'h12345678);
    chk("mthi_no_busy", busy_seen, 32'd0);

    // divu aborted by reset mid-op
    cycle(1, 4'd4, 32'd100, 32'd7, 0);
    idle(3);
    Start = 0; MDOp = 0;
    reset_n = 0;
    #1;
    chk("rst_busy", {31'b0, Busy}, 32'h0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    model_reset();
    idle(2);
    reset_n = 1;
    idle(12);
    chk("rst_no_late_lo", LO, 32'h0);

    // randomized ops, with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        Start = 0; MDOp = 0; Req = 0;
        reset_n = 0;
        #1 model_reset();
        compare();
        @(negedge clk);
        reset_n = 1;
      end
      cycle(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 11)), rand_val(), rand_val(),
            ($urandom_range(0, 7) == 0));
    end
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
